// File: rtl/axi_rd_arbiter_pkg.sv
// AXI read-channel field widths and the AR request record shared by the read arbiter.
package axi_rd_arbiter_pkg;

  localparam int ID_W   = 16;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int DATA_W = 512;
  localparam int RESP_W = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ar_req_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI bus bundle (read channels plus write handshakes); master drives AR/rready, slave the reverse.
interface axi_bus_t;
  import axi_rd_arbiter_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [SIZE_W-1:0] arsize;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [RESP_W-1:0] rresp;
  logic              rvalid;
  logic              rready;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;

  modport master (
    output arid, araddr, arlen, arsize, arvalid, rready, awvalid, wvalid, bready,
    input  arready, rid, rdata, rlast, rresp, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arvalid, rready, awvalid, wvalid, bready,
    output arready, rid, rdata, rlast, rresp, rvalid, awready, wready, bvalid
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter; grant is combinational and gated by advance, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] idx, sel;
  logic          found;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    sel      = rr_ptr_q;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    if (advance && found) begin
      grant[sel] = 1'b1;
      rr_ptr_d   = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI read arbiter: one registered AR stage (1 cycle), R routed back by ID tag (0 cycles).
// AR grants stall while the output stage is full and unaccepted; AXI_RD_ARB_STATS_EN adds grant counters.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int ID_LSB          = 12,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi_bus_t.slave                  req [N_PORTS],
  axi_bus_t.master                 out,
  output logic                     err_bad_rid,
  output logic [N_PORTS-1:0][31:0] stat_grants
);

  localparam int PORT_BITS = $clog2(N_PORTS);
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  ar_req_t              in_ar [N_PORTS];
  logic [N_PORTS-1:0]   in_rrdy, eligible, grant, cnt_inc, cnt_dec, unused_wr;
  logic [CNT_W-1:0]     cnt_q [N_PORTS];
  logic [CNT_W-1:0]     cnt_d [N_PORTS];
  ar_req_t              out_ar_q, out_ar_d;
  logic                 out_vld_q, out_vld_d, err_q, err_d;
  logic                 advance, r_bad, r_done, r_rdy, unused_out_wr;
  logic [PORT_BITS-1:0] r_tag;

  assign r_tag  = out.rid[ID_LSB +: PORT_BITS];
  assign r_bad  = int'(r_tag) >= N_PORTS;
  assign r_done = out.rvalid && r_rdy && out.rlast;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic [ID_W-1:0] id_tagged;

    always_comb begin
      id_tagged = req[p].arid;
      id_tagged[ID_LSB +: PORT_BITS] = PORT_BITS'(p);
    end

    assign in_ar[p]    = '{id: id_tagged, addr: req[p].araddr, len: req[p].arlen, size: req[p].arsize};
    assign in_rrdy[p]  = req[p].rready;
    assign eligible[p] = req[p].arvalid && (cnt_q[p] < CNT_MAX);
    assign cnt_inc[p]  = grant[p];
    // A stray rlast on an idle port must not underflow its counter.
    assign cnt_dec[p]  = r_done && (r_tag == PORT_BITS'(p)) && (cnt_q[p] != '0);

    assign req[p].arready = grant[p];
    assign req[p].rid     = out.rid;
    assign req[p].rdata   = out.rdata;
    assign req[p].rlast   = out.rlast;
    assign req[p].rresp   = out.rresp;
    assign req[p].rvalid  = out.rvalid && (r_tag == PORT_BITS'(p));
    assign req[p].awready = 1'b0;
    assign req[p].wready  = 1'b0;
    assign req[p].bvalid  = 1'b0;
    assign unused_wr[p]   = req[p].awvalid ^ req[p].wvalid ^ req[p].bready;
  end

  assign advance = !out_vld_q || out.arready;

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req     (eligible),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    out_vld_d = out_vld_q && !out.arready;
    out_ar_d  = out_ar_q;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant[p]) begin
        out_vld_d = 1'b1;
        out_ar_d  = in_ar[p];
      end
    end
  end

  // Unknown tags are swallowed so a corrupt ID cannot wedge the R channel.
  always_comb begin
    r_rdy = r_bad;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_tag == PORT_BITS'(p)) r_rdy = in_rrdy[p];
    end
  end

  always_comb begin
    err_d = err_q || (out.rvalid && r_bad);
    for (int p = 0; p < N_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (cnt_inc[p] && !cnt_dec[p])      cnt_d[p] = cnt_q[p] + CNT_W'(1);
      else if (!cnt_inc[p] && cnt_dec[p]) cnt_d[p] = cnt_q[p] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_vld_q <= 1'b0;
      out_ar_q  <= '0;
      err_q     <= 1'b0;
      for (int p = 0; p < N_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_ar_q  <= out_ar_d;
      err_q     <= err_d;
      for (int p = 0; p < N_PORTS; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign out.arvalid   = out_vld_q;
  assign out.arid      = out_ar_q.id;
  assign out.araddr    = out_ar_q.addr;
  assign out.arlen     = out_ar_q.len;
  assign out.arsize    = out_ar_q.size;
  assign out.rready    = r_rdy;
  assign out.awvalid   = 1'b0;
  assign out.wvalid    = 1'b0;
  assign out.bready    = 1'b1;
  assign unused_out_wr = out.awready ^ out.wready ^ out.bvalid;
  assign err_bad_rid   = err_q;

`ifdef AXI_RD_ARB_STATS_EN
  logic [31:0] stat_q [N_PORTS];
  logic [31:0] stat_d [N_PORTS];

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      stat_d[p] = stat_q[p];
      if (grant[p] && (stat_q[p] != '1)) stat_d[p] = stat_q[p] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) for (int p = 0; p < N_PORTS; p++) stat_q[p] <= '0;
    else       for (int p = 0; p < N_PORTS; p++) stat_q[p] <= stat_d[p];
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_stat
    assign stat_grants[p] = stat_q[p];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: table-driven AR arbitration plus hand sequences for limits, stalls and R routing.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- 4-port instance ----------------
  axi_bus_t req4 [4] ();
  axi_bus_t out4 ();
  logic [3:0]        vld4 = '0, rrdy4 = '0, ardy4_mon, rvld4_mon;
  logic              o4_ardy = 1'b1, o4_rvld = 1'b0, o4_rlast = 1'b0;
  logic [15:0]       o4_rid = '0;
  logic [511:0]      o4_rdata = '0;
  logic [511:0]      rdata3_mon;
  logic [15:0]       rid0_mon;
  logic [2:0]        wr_tie_mon;
  logic              err4;
  logic [3:0][31:0]  stat4;

  for (genvar g = 0; g < 4; g++) begin : g_req4
    assign req4[g].arvalid = vld4[g];
    assign req4[g].arid    = (g == 0) ? 16'h0005 : 16'h3005 + 16'(g);
    assign req4[g].araddr  = 64'(4096 * (g + 1));
    assign req4[g].arlen   = 8'(g);
    assign req4[g].arsize  = 3'd6;
    assign req4[g].rready  = rrdy4[g];
    assign req4[g].awvalid = 1'b0;
    assign req4[g].wvalid  = 1'b0;
    assign req4[g].bready  = 1'b1;
    assign ardy4_mon[g]    = req4[g].arready;
    assign rvld4_mon[g]    = req4[g].rvalid;
  end
  assign rdata3_mon = req4[3].rdata;
  assign rid0_mon   = req4[0].rid;
  assign wr_tie_mon = {req4[0].awready, req4[0].wready, req4[0].bvalid};

  assign out4.arready = o4_ardy;
  assign out4.rvalid  = o4_rvld;
  assign out4.rid     = o4_rid;
  assign out4.rdata   = o4_rdata;
  assign out4.rlast   = o4_rlast;
  assign out4.rresp   = 2'b00;
  assign out4.awready = 1'b0;
  assign out4.wready  = 1'b0;
  assign out4.bvalid  = 1'b0;

  axi_rd_arbiter #(.N_PORTS(4), .ID_LSB(12), .MAX_OUTSTANDING(8)) dut4 (
    .clk (clk), .rstn (rstn), .req (req4), .out (out4),
    .err_bad_rid (err4), .stat_grants (stat4)
  );

  // ---------------- 3-port instance for the bad-tag case ----------------
  axi_bus_t req3 [3] ();
  axi_bus_t out3 ();
  logic [2:0]       rvld3_mon;
  logic             o3_rvld = 1'b0;
  logic [15:0]      o3_rid = '0;
  logic             err3;
  logic [2:0][31:0] stat3;

  for (genvar g = 0; g < 3; g++) begin : g_req3
    assign req3[g].arvalid = 1'b0;
    assign req3[g].arid    = '0;
    assign req3[g].araddr  = '0;
    assign req3[g].arlen   = '0;
    assign req3[g].arsize  = '0;
    assign req3[g].rready  = 1'b0;
    assign req3[g].awvalid = 1'b0;
    assign req3[g].wvalid  = 1'b0;
    assign req3[g].bready  = 1'b1;
    assign rvld3_mon[g]    = req3[g].rvalid;
  end
  assign out3.arready = 1'b1;
  assign out3.rvalid  = o3_rvld;
  assign out3.rid     = o3_rid;
  assign out3.rdata   = '0;
  assign out3.rlast   = 1'b1;
  assign out3.rresp   = 2'b00;
  assign out3.awready = 1'b0;
  assign out3.wready  = 1'b0;
  assign out3.bvalid  = 1'b0;

  axi_rd_arbiter #(.N_PORTS(3), .ID_LSB(12), .MAX_OUTSTANDING(8)) dut3 (
    .clk (clk), .rstn (rstn), .req (req3), .out (out3),
    .err_bad_rid (err3), .stat_grants (stat3)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+5.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; vld4 = '0; rrdy4 = '0; o4_ardy = 1'b1; o4_rvld = 1'b0; o4_rlast = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic        ardy;
    logic [3:0]  exp_rdy;
    logic        exp_ovld;
    logic        chk_pl;
    logic [15:0] exp_id;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vt [10];
  logic [31:0] exp_stat;

  initial begin
    vt[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 16'h0000, 64'h0};
    vt[1] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 1'b1, 16'h0000, 64'h0};
    vt[2] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 16'h0005, 64'h1000};
    vt[3] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h0000, 64'h0};
    vt[4] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 16'h1006, 64'h2000};
    vt[5] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 16'h2007, 64'h3000};
    vt[6] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 16'h3008, 64'h4000};
    vt[7] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 16'h0005, 64'h1000};
    vt[8] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 16'h1006, 64'h2000};
    vt[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 64'h0};

    do_reset();
    chk("reset_err", 64'(err4), 64'h0);
    chk("reset_stat0", 64'(stat4[0]), 64'h0);
    chk("tie_wr_req", 64'(wr_tie_mon), 64'h0);
    chk("tie_wr_out", 64'({out4.awvalid, out4.wvalid, out4.bready}), 64'h1);

    // Single-port issue and round-robin rotation.
    for (int i = 0; i < 10; i++) begin
      vld4 = vt[i].vld; o4_ardy = vt[i].ardy;
      #4;
      chk($sformatf("vec%0d_arready", i), 64'(ardy4_mon), 64'(vt[i].exp_rdy));
      chk($sformatf("vec%0d_arvalid", i), 64'(out4.arvalid), 64'(vt[i].exp_ovld));
      if (vt[i].chk_pl) begin
        chk($sformatf("vec%0d_arid", i), 64'(out4.arid), 64'(vt[i].exp_id));
        chk($sformatf("vec%0d_araddr", i), out4.araddr, vt[i].exp_addr);
      end
      next_cycle();
    end

    // Port 2 outstanding limit, released by one final R beat.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      vld4 = 4'b0100;
      #4;
      chk($sformatf("lim_issue%0d", k), 64'(ardy4_mon), (k < 8) ? 64'h4 : 64'h0);
      next_cycle();
    end
    o4_rvld = 1'b1; o4_rid = 16'h2000; o4_rlast = 1'b1; rrdy4 = 4'b0100;
    #4;
    chk("lim_rvalid", 64'(rvld4_mon), 64'h4);
    chk("lim_rready", 64'(out4.rready), 64'h1);
    chk("lim_still_stalled", 64'(ardy4_mon), 64'h0);
    next_cycle();
    o4_rvld = 1'b0; o4_rlast = 1'b0; rrdy4 = '0;
    #4;
    chk("lim_regrant", 64'(ardy4_mon), 64'h4);
    next_cycle();
    vld4 = '0;

    // Output stage held by arready=0 for five cycles.
    do_reset();
    vld4 = 4'b0011; o4_ardy = 1'b1;
    #4;
    chk("stall_first_grant", 64'(ardy4_mon), 64'h1);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      o4_ardy = 1'b0;
      #4;
      chk($sformatf("stall%0d_arready", k), 64'(ardy4_mon), 64'h0);
      chk($sformatf("stall%0d_arvalid", k), 64'(out4.arvalid), 64'h1);
      chk($sformatf("stall%0d_arid", k), 64'(out4.arid), 64'h0005);
      chk($sformatf("stall%0d_araddr", k), out4.araddr, 64'h1000);
      next_cycle();
    end
    o4_ardy = 1'b1;
    #4;
    chk("release_arready", 64'(ardy4_mon), 64'h2);
    chk("release_arid", 64'(out4.arid), 64'h0005);
    next_cycle();
    vld4 = '0;
    #4;
    chk("drain_arid", 64'(out4.arid), 64'h1006);
    chk("drain_arvalid", 64'(out4.arvalid), 64'h1);
    next_cycle();
    #4;
    chk("idle_arvalid", 64'(out4.arvalid), 64'h0);
    next_cycle();

    // R routing with requester back-pressure.
    o4_rvld = 1'b1; o4_rid = 16'h1abc; o4_rlast = 1'b0; rrdy4 = 4'b0000;
    o4_rdata = 512'hdead_beef_0123_4567;
    #4;
    chk("route_rready_low", 64'(out4.rready), 64'h0);
    chk("route_rvalid_onehot", 64'(rvld4_mon), 64'h2);
    chk("route_rdata_bcast", rdata3_mon[63:0], 64'hdead_beef_0123_4567);
    chk("route_rid_tagged", 64'(rid0_mon), 64'h1abc);
    next_cycle();
    rrdy4 = 4'b0010;
    #4;
    chk("route_rready_high", 64'(out4.rready), 64'h1);
    next_cycle();
    o4_rvld = 1'b0; rrdy4 = '0;

    // Same-cycle AR grant and final R beat on port 1 at cnt=4.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      vld4 = 4'b0010;
      #4;
      chk($sformatf("same_pre%0d", k), 64'(ardy4_mon), 64'h2);
      next_cycle();
    end
    o4_rvld = 1'b1; o4_rid = 16'h1000; o4_rlast = 1'b1; rrdy4 = 4'b0010;
    #4;
`ifdef AXI_RD_ARB_STATS_EN
    exp_stat = 32'd4;
`else
    exp_stat = 32'd0;
`endif
    chk("same_arready", 64'(ardy4_mon), 64'h2);
    chk("same_rready", 64'(out4.rready), 64'h1);
    chk("same_stat_before", 64'(stat4[1]), 64'(exp_stat));
    next_cycle();
    o4_rvld = 1'b0; o4_rlast = 1'b0; rrdy4 = '0;
`ifdef AXI_RD_ARB_STATS_EN
    exp_stat = 32'd5;
`endif
    #4;
    chk("same_stat_after", 64'(stat4[1]), 64'(exp_stat));
    next_cycle();
    // Count held at 4 → exactly four more grants fit, beginning with this cycle's.
    for (int k = 0; k < 5; k++) begin
      #4;
      chk($sformatf("same_post%0d", k), 64'(ardy4_mon), (k < 3) ? 64'h2 : 64'h0);
      next_cycle();
    end
    vld4 = '0;

    // Bad tag on the 3-port instance.
    o3_rvld = 1'b1; o3_rid = 16'h3000;
    #4;
    chk("bad_rready", 64'(out3.rready), 64'h1);
    chk("bad_no_rvalid", 64'(rvld3_mon), 64'h0);
    chk("bad_err_pre", 64'(err3), 64'h0);
    next_cycle();
    o3_rvld = 1'b0; o3_rid = '0;
    #4;
    chk("bad_err_set", 64'(err3), 64'h1);
    next_cycle();
    #4;
    chk("bad_err_sticky", 64'(err3), 64'h1);
    chk("bad_err_other_inst", 64'(err4), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin arbiter that shares one AXI read master port among N_PORTS requesters. It serialises their AR requests through a one-stage registered output, tags each request's ID with the port index, and steers R beats back by that tag. A per-port limit on outstanding bursts stops one requester from monopolising memory bandwidth. It sits between task-unit/cache read clients and the memory-side pipeline stage, and handles read traffic only.

## Interface
- N_PORTS, 4: number of requesters; 2..8.
- ID_LSB, 12: lowest arid/rid bit of the port tag field; tag width PORT_BITS = $clog2(N_PORTS); ID_LSB+PORT_BITS ≤ 16.
- MAX_OUTSTANDING, 8: maximum AR bursts in flight per port; ≥1.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req[N_PORTS]  axi_bus_t.slave  —  requester side. Used fields: arid 16, araddr 64, arlen 8, arsize 3, arvalid/arready; rid 16, rdata 512, rlast 1, rresp 2, rvalid/rready.
- out  axi_bus_t.master  —  memory side, same read fields.
- err_bad_rid  out  1  sticky flag; set by an R beat whose tag is ≥ N_PORTS.
- stat_grants  out  N_PORTS×32  per-port grant counts; see Configuration.

## Operation
- Eligible(p) = req[p].arvalid & (cnt[p] < MAX_OUTSTANDING).
- Grant: one eligible port per cycle, chosen round-robin starting at rr_ptr. A grant fires only when the output register is empty or out.arready=1 in the same cycle. After a grant to p, rr_ptr ← (p+1) mod N_PORTS. If no port is granted, rr_ptr holds.
- req[p].arready = grant[p], combinational.
- The output register captures {arid with bits [ID_LSB +: PORT_BITS] replaced by p, araddr, arlen, arsize} and sets out.arvalid. It clears on out.arready unless a new grant reloads it in the same cycle.
- Outstanding counters:
  - cnt[p] increments on a req[p] AR handshake.
  - cnt[p] decrements on an out R handshake with rlast=1 and tag = p.
  - Simultaneous increment and decrement leaves cnt[p] unchanged.
  - Counter width is $clog2(MAX_OUTSTANDING+1); the counter never wraps.
- R routing is combinational. Let t = out.rid[ID_LSB +: PORT_BITS].
  - req[t].rvalid = out.rvalid; out.rready = req[t].rready.
  - rid, rdata, rlast and rresp broadcast to all ports; rvalid is 0 on every port ≠ t.
  - rid is returned with the tag bits intact. The original bits at that position are not restored, so requesters must not depend on them.
- Bad tag (t ≥ N_PORTS): out.rready=1, the beat is dropped, err_bad_rid is set until reset, and no counter changes.
- Write channels are tied off:
  - req[*].awready=0, req[*].wready=0, req[*].bvalid=0.
  - out.awvalid=0, out.wvalid=0, out.bready=1.

## Timing
- Reset values: out.arvalid=0, out AR payload=0, rr_ptr=0, all cnt=0, err_bad_rid=0, stat_grants=0.
- AR latency: a grant in cycle c gives out.arvalid=1 in cycle c+1.
- Sustained throughput is 1 AR per cycle when out.arready stays high.
- R path latency: 0 cycles, combinational.
- out.arvalid and the AR payload hold stable while out.arready=0 (AXI rule).
- req[p].arready never asserts while out.arvalid=1 & out.arready=0.
- Reset mid-operation drops the registered AR and zeroes the counters. The memory side must be reset in the same cycle.

## Configuration
- AXI_RD_ARB_STATS_EN defined: a per-port 32-bit saturating counter increments on each grant and drives stat_grants.
- AXI_RD_ARB_STATS_EN undefined: no counters are built and stat_grants is tied to 0.

## Structure
- Shared package holds:
  - AXI field width constants (ID 16, ADDR 64, LEN 8, SIZE 3, DATA 512, RESP 2).
  - Packed struct ar_req_t {id, addr, len, size}.
- Sub-module rr_arbiter #(N): inputs req[N] and advance; outputs onehot grant[N]; owns rr_ptr.

## Test plan
- Port 0 only, arid=0x0005, araddr=0x1000, out.arready=1 → out.arvalid one cycle later with arid=0x0005 (tag 0), araddr=0x1000; req[0].arready pulses once.
- All 4 ports continuously valid, arready=1 → grant order 0,1,2,3,0,…, one per cycle; each cnt increments by 1 per grant.
- Port 2 issues 8 bursts with no R returned → the 9th is stalled (arready=0). One R beat with rlast=1 and tag 2 → port 2 granted next cycle.
- out.arready=0 for 5 cycles with two ports valid → out.arvalid and payload stable, no req arready; on release, the granted AR drains and the next grant follows.
- R beat with rid tag=1 and req[1].rready=0 → out.rready=0, no other port sees rvalid. With N_PORTS=3, a beat with tag=3 → dropped, err_bad_rid=1.
- Same-cycle AR grant and final R beat for port 1 with cnt=4 → cnt stays 4. With stats enabled, stat_grants[1] increments by 1.
